// File: rtl/lane_merge_2a1_if.sv
// Lane-side and merged-stream signals of the two-lane merger, grouped as one bundle.
// The master side feeds lane words; the slave side is the merger itself.
interface lane_merge_2a1_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          active;
    logic [31:0]   data_0;
    logic          valid_0;
    logic [31:0]   data_1;
    logic          valid_1;
    logic [31:0]   data_out;
    logic          valid_out;
    logic          lane_out;
    logic [CW-1:0] count_0;
    logic [CW-1:0] count_1;
    logic          overflow_0;
    logic          overflow_1;

    modport master (
        output active, data_0, valid_0, data_1, valid_1,
        input  data_out, valid_out, lane_out, count_0, count_1, overflow_0, overflow_1
    );

    modport slave (
        input  active, data_0, valid_0, data_1, valid_1,
        output data_out, valid_out, lane_out, count_0, count_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/lane_merge_2a1.sv
// Two-lane to one-stream merger: per-lane FIFOs feeding an alternating lane 0 / lane 1
// arbiter that rebuilds the word order split by the upstream 1:2 demux.
module lane_merge_2a1 #(
    parameter int DEPTH        = 4,
    parameter bit STRICT_ORDER = 1'b1
) (
    input  logic              clk_2f,
    input  logic              reset,
    lane_merge_2a1_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]    valid_in;
    logic [31:0]   data_in [2];
    logic [1:0]    empty;
    logic [1:0]    full;
    logic [1:0]    pop;
    logic [31:0]   head [2];
    logic [CW-1:0] count [2];
    logic [1:0]    overflow;

    logic          sel_reg;
    logic          pop_lane;
    logic          any_pop;
    logic [31:0]   data_out_reg;
    logic          valid_out_reg;
    logic          lane_out_reg;

    assign valid_in   = {bus.valid_1, bus.valid_0};
    assign data_in[0] = bus.data_0;
    assign data_in[1] = bus.data_1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [31:0]   mem_reg [DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;
            logic          overflow_reg;
            logic          push;

            assign empty[gi]  = (count_reg == '0);
            assign full[gi]   = (count_reg == CW'(DEPTH));
            // A full lane still takes a word when its head leaves on the same edge.
            assign push       = valid_in[gi] && (!full[gi] || pop[gi]);
            assign count_next = count_reg + CW'(push) - CW'(pop[gi]);

            always_ff @(posedge clk_2f) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= data_in[gi];
                end
            end

            always_ff @(posedge clk_2f) begin
                if (reset) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    count_reg <= count_next;
                    if (valid_in[gi] && full[gi] && !pop[gi]) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end

            assign head[gi]     = mem_reg[rd_ptr_reg];
            assign count[gi]    = count_reg;
            assign overflow[gi] = overflow_reg;
        end
    endgenerate

    // Serving the other lane out of turn leaves sel alone so the starved lane keeps its slot.
    always_comb begin
        pop      = '0;
        pop_lane = sel_reg;
        if (bus.active) begin
            if (!empty[sel_reg]) begin
                pop[sel_reg] = 1'b1;
            end else if (!STRICT_ORDER && !empty[~sel_reg]) begin
                pop[~sel_reg] = 1'b1;
                pop_lane      = ~sel_reg;
            end
        end
    end

    assign any_pop = |pop;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel_reg       <= 1'b0;
            data_out_reg  <= '0;
            valid_out_reg <= 1'b0;
            lane_out_reg  <= 1'b0;
        end else begin
            valid_out_reg <= any_pop;
            if (any_pop) begin
                data_out_reg <= head[pop_lane];
                lane_out_reg <= pop_lane;
                if (pop_lane == sel_reg) begin
                    sel_reg <= ~sel_reg;
                end
            end
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.valid_out  = valid_out_reg;
    assign bus.lane_out   = lane_out_reg;
    assign bus.count_0    = count[0];
    assign bus.count_1    = count[1];
    assign bus.overflow_0 = overflow[0];
    assign bus.overflow_1 = overflow[1];
endmodule

// File: tb/tb_lane_merge_2a1.sv
// Directed bench for lane_merge_2a1: a strict-order instance and a work-conserving instance
// share clock and reset; expected words and lanes are hand-computed per step.
module tb_lane_merge_2a1;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    lane_merge_2a1_if #(.DEPTH(4)) if_s ();
    lane_merge_2a1_if #(.DEPTH(4)) if_w ();

    lane_merge_2a1 #(.DEPTH(4), .STRICT_ORDER(1'b1)) u_strict (
        .clk_2f (clk),
        .reset  (reset),
        .bus    (if_s.slave)
    );

    lane_merge_2a1 #(.DEPTH(4), .STRICT_ORDER(1'b0)) u_work (
        .clk_2f (clk),
        .reset  (reset),
        .bus    (if_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_s(input string tag, input logic [31:0] d, input logic l);
        check({tag, "_valid"}, 32'(if_s.valid_out), 32'd1);
        check({tag, "_data"}, if_s.data_out, d);
        check({tag, "_lane"}, 32'(if_s.lane_out), 32'(l));
        $display("out %s data=%h lane=%0d", tag, if_s.data_out, if_s.lane_out);
    endtask

    logic [31:0] exp4 [8];
    logic [31:0] exp5 [9];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        if_s.active = 1'b0; if_s.valid_0 = 1'b0; if_s.valid_1 = 1'b0;
        if_s.data_0 = '0;   if_s.data_1 = '0;
        if_w.active = 1'b0; if_w.valid_0 = 1'b0; if_w.valid_1 = 1'b0;
        if_w.data_0 = '0;   if_w.data_1 = '0;
        tick(); tick();
        check("rst_valid", 32'(if_s.valid_out), 32'd0);
        check("rst_data", if_s.data_out, 32'h0);
        check("rst_lane", 32'(if_s.lane_out), 32'd0);
        check("rst_count0", 32'(if_s.count_0), 32'd0);
        check("rst_count1", 32'(if_s.count_1), 32'd0);
        check("rst_ovf0", 32'(if_s.overflow_0), 32'd0);
        reset = 1'b0;

        // 1: both lanes push on one edge, lane 0 word leads
        if_s.active = 1'b1;
        if_s.valid_0 = 1'b1; if_s.data_0 = 32'hFFFFEEEE;
        if_s.valid_1 = 1'b1; if_s.data_1 = 32'hFFEEEEEE;
        tick();
        if_s.valid_0 = 1'b0; if_s.valid_1 = 1'b0;
        check("t1_nobypass", 32'(if_s.valid_out), 32'd0);
        check("t1_count0", 32'(if_s.count_0), 32'd1);
        check("t1_count1", 32'(if_s.count_1), 32'd1);
        tick(); out_s("t1_w0", 32'hFFFFEEEE, 1'b0);
        tick(); out_s("t1_w1", 32'hFFEEEEEE, 1'b1);
        tick();
        check("t1_idle", 32'(if_s.valid_out), 32'd0);
        check("t1_hold", if_s.data_out, 32'hFFEEEEEE);

        // 2: strict order waits for lane 0
        if_s.valid_1 = 1'b1; if_s.data_1 = 32'hAAAA1234;
        tick();
        if_s.valid_1 = 1'b0;
        tick();
        check("t2_wait_valid", 32'(if_s.valid_out), 32'd0);
        check("t2_count1", 32'(if_s.count_1), 32'd1);
        if_s.valid_0 = 1'b1; if_s.data_0 = 32'h12345678;
        tick();
        if_s.valid_0 = 1'b0;
        tick(); out_s("t2_w0", 32'h12345678, 1'b0);
        tick(); out_s("t2_w1", 32'hAAAA1234, 1'b1);
        tick();
        check("t2_idle", 32'(if_s.valid_out), 32'd0);

        // 3: work-conserving instance serves lane 1 out of turn, sel stays on lane 0
        if_w.active = 1'b1;
        if_w.valid_1 = 1'b1; if_w.data_1 = 32'hCCEEEEEE;
        tick();
        if_w.valid_1 = 1'b0;
        check("t3_nobypass", 32'(if_w.valid_out), 32'd0);
        tick();
        check("t3_valid", 32'(if_w.valid_out), 32'd1);
        check("t3_data", if_w.data_out, 32'hCCEEEEEE);
        check("t3_lane", 32'(if_w.lane_out), 32'd1);
        $display("out t3 data=%h lane=%0d", if_w.data_out, if_w.lane_out);
        if_w.valid_0 = 1'b1; if_w.data_0 = 32'hD0000000;
        if_w.valid_1 = 1'b1; if_w.data_1 = 32'hD1000000;
        tick();
        if_w.valid_0 = 1'b0; if_w.valid_1 = 1'b0;
        tick();
        check("t3_sel_data", if_w.data_out, 32'hD0000000);
        check("t3_sel_lane", 32'(if_w.lane_out), 32'd0);
        tick();
        check("t3_next_data", if_w.data_out, 32'hD1000000);
        check("t3_next_lane", 32'(if_w.lane_out), 32'd1);

        // 4: fill lane 0 past DEPTH while idle, then drain interleaved with lane 1
        if_s.active = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_s.valid_0 = 1'b1; if_s.data_0 = 32'h40000000 + 32'(i);
            tick();
            check("t4_idle_valid", 32'(if_s.valid_out), 32'd0);
        end
        if_s.valid_0 = 1'b0;
        check("t4_count0", 32'(if_s.count_0), 32'd4);
        check("t4_ovf0", 32'(if_s.overflow_0), 32'd1);
        check("t4_ovf1", 32'(if_s.overflow_1), 32'd0);
        exp4 = '{32'h40000000, 32'h51000000, 32'h40000001, 32'h51000001,
                 32'h40000002, 32'h51000002, 32'h40000003, 32'h51000003};
        if_s.active = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_s.valid_1 = (i < 4);
            if_s.data_1  = 32'h51000000 + 32'(i);
            tick();
            out_s($sformatf("t4_d%0d", i), exp4[i], 1'(i % 2));
        end
        if_s.valid_1 = 1'b0;
        tick();
        check("t4_lost_word", 32'(if_s.valid_out), 32'd0);
        check("t4_empty0", 32'(if_s.count_0), 32'd0);

        // 5: push into a full lane on the edge it pops
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5_ovf_cleared", 32'(if_s.overflow_0), 32'd0);
        if_s.active = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_s.valid_0 = 1'b1; if_s.data_0 = 32'h60000000 + 32'(i);
            if_s.valid_1 = 1'b1; if_s.data_1 = 32'h70000000 + 32'(i);
            tick();
        end
        check("t5_full0", 32'(if_s.count_0), 32'd4);
        if_s.active = 1'b1;
        if_s.valid_0 = 1'b1; if_s.data_0 = 32'hBBBBAAAA;
        if_s.valid_1 = 1'b0;
        tick();
        if_s.valid_0 = 1'b0;
        out_s("t5_pop", 32'h60000000, 1'b0);
        check("t5_count0", 32'(if_s.count_0), 32'd4);
        check("t5_no_ovf", 32'(if_s.overflow_0), 32'd0);
        exp5 = '{32'h70000000, 32'h60000001, 32'h70000001, 32'h60000002, 32'h70000002,
                 32'h60000003, 32'h70000003, 32'hBBBBAAAA, 32'h0};
        for (int i = 0; i < 8; i++) begin
            tick();
            out_s($sformatf("t5_d%0d", i), exp5[i], 1'((i + 1) % 2));
        end

        // 6: reset with buffered words and a sticky overflow discards everything
        if_s.active = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_s.valid_0 = (i < 2); if_s.data_0 = 32'h80000000 + 32'(i);
            if_s.valid_1 = 1'b1;    if_s.data_1 = 32'h81000000 + 32'(i);
            tick();
        end
        if_s.valid_0 = 1'b0; if_s.valid_1 = 1'b0;
        check("t6_pre_count0", 32'(if_s.count_0), 32'd2);
        check("t6_pre_ovf1", 32'(if_s.overflow_1), 32'd1);
        reset = 1'b1; if_s.active = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_count0", 32'(if_s.count_0), 32'd0);
        check("t6_count1", 32'(if_s.count_1), 32'd0);
        check("t6_valid", 32'(if_s.valid_out), 32'd0);
        check("t6_ovf1", 32'(if_s.overflow_1), 32'd0);
        check("t6_data", if_s.data_out, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_stale", 32'(if_s.valid_out), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
